// File: rtl/pulse_repeat_pkg.sv
// Shared types and default widths for the pulse repeat generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_repeat_pkg;

  typedef enum logic [0:0] {IDLE, RUN} prg_state_e;

  localparam int PRG_CNT_W = 8;
  localparam int PRG_GAP_W = 8;

endpackage

// File: rtl/prg_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
// Latency: load/decrement take effect on the next rising edge.
// Backpressure: none; the count only moves when load or dec is asserted.
module prg_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_repeat_gen.sv
// Repeated event source: N (or unbounded) single-cycle pulses spaced gap+1 cycles. Optional PRG_ERR_EN.
// Latency: first pulse in the cycle right after the edge that accepts start; all outputs registered.
// Backpressure: none; start is ignored while busy, stop aborts at the next edge with no further pulses.
module pulse_repeat_gen
  import pulse_repeat_pkg::*;
#(
  parameter int CNT_W = PRG_CNT_W,
  parameter int GAP_W = PRG_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             forever_mode,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             stop,
  output logic             busy,
  output logic             pulse_o,
  output logic [CNT_W-1:0] pulse_idx,
  output logic             done,
  output logic             err
);

  prg_state_e       state, state_nxt;
  logic             pulse_nxt, done_nxt;
  logic [CNT_W-1:0] idx_nxt;
  logic             forever_q, forever_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;

  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_load_val, gap_cnt;
  logic             rem_load, rem_dec, rem_zero;
  logic [CNT_W-1:0] rem_load_val, rem_cnt;

  // Gap timer: reloaded on every pulse, counts down to zero between pulses.
  // The first load comes straight from the port; reloads use the latched copy
  // so mid-run changes to gap have no effect.
  assign gap_load_val = (state == IDLE) ? gap : gap_q;

  prg_down_counter #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (gap_load_val),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  // Pulses still owed after the current one; zero during the last pulse.
  assign rem_load_val = repeat_cnt - CNT_W'(1);

  prg_down_counter #(.W(CNT_W)) u_rem_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rem_load),
    .dec      (rem_dec),
    .load_val (rem_load_val),
    .cnt      (rem_cnt),
    .zero     (rem_zero)
  );

  // State and registered outputs; every output is a flop so consumers see clean strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_o   <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      forever_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state     <= state_nxt;
      pulse_o   <= pulse_nxt;
      done      <= done_nxt;
      pulse_idx <= idx_nxt;
      forever_q <= forever_nxt;
      gap_q     <= gap_nxt;
    end
  end

  // Next-state and next-output decode; stop always beats start and pulse launch.
  always_comb begin
    state_nxt   = state;
    pulse_nxt   = 1'b0;
    done_nxt    = 1'b0;
    idx_nxt     = pulse_idx;
    forever_nxt = forever_q;
    gap_nxt     = gap_q;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    rem_load    = 1'b0;
    rem_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (forever_mode || (repeat_cnt != '0)) begin
            state_nxt   = RUN;
            pulse_nxt   = 1'b1;
            idx_nxt     = '0;
            forever_nxt = forever_mode;
            gap_nxt     = gap;
            gap_load    = 1'b1;
            rem_load    = 1'b1;
            done_nxt    = !forever_mode && (repeat_cnt == CNT_W'(1));
          end else begin
            // Zero-length counted run completes immediately without pulsing.
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!forever_q && rem_zero) begin
          // Last pulse was emitted in this cycle; drop busy next cycle.
          state_nxt = IDLE;
        end else if (gap_zero) begin
          pulse_nxt = 1'b1;
          idx_nxt   = pulse_idx + CNT_W'(1);
          gap_load  = 1'b1;
          rem_dec   = !forever_q;
          done_nxt  = !forever_q && (rem_cnt == CNT_W'(1));
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

`ifdef PRG_ERR_EN
  // Sticky flag for a start request arriving while a run is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start && (state == RUN)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_repeat_gen.sv
// Directed bench for pulse_repeat_gen: counted, zero-count, forever, stop, busy-start, reset.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_pulse_repeat_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       forever_mode;
  logic [7:0] repeat_cnt;
  logic [7:0] gap;
  logic       stop;
  logic       busy;
  logic       pulse_o;
  logic [7:0] pulse_idx;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;

`ifdef PRG_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  pulse_repeat_gen #(.CNT_W(8), .GAP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .forever_mode (forever_mode),
    .repeat_cnt   (repeat_cnt),
    .gap          (gap),
    .stop         (stop),
    .busy         (busy),
    .pulse_o      (pulse_o),
    .pulse_idx    (pulse_idx),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; forever_mode = 1'b0;
    repeat_cnt = 8'd0; gap = 8'd0;
    #2;
    vectors++;
    if ({busy, pulse_o, done, err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset flags: got busy/pulse/done/err=%b want 0000", {busy, pulse_o, done, err});
    end
    vectors++;
    if (pulse_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL reset pulse_idx: got %0d want 0", pulse_idx);
    end
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({busy, pulse_o, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL post-reset idle: got busy/pulse/done=%b want 000", {busy, pulse_o, done});
    end
  endtask

  // Pulse k lands at offset 1+k*(g+1); done on the last, busy through it.
  task automatic test_counted(input int n, input int g);
    int last;
    logic ep, eb, ed;
    logic [7:0] ei;
    repeat_cnt = 8'(n); gap = 8'(g); forever_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    last = (n - 1) * (g + 1) + 1;
    for (int offs = 1; offs <= last + 3; offs++) begin
      ep = (offs <= last) && (((offs - 1) % (g + 1)) == 0);
      eb = (offs <= last);
      ed = (offs == last);
      ei = 8'((offs - 1) / (g + 1));
      vectors++;
      if (pulse_o !== ep) begin
        miscompares++;
        $display("FAIL counted n=%0d g=%0d pulse_o @t+%0d: got %b want %b", n, g, offs, pulse_o, ep);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL counted n=%0d g=%0d busy @t+%0d: got %b want %b", n, g, offs, busy, eb);
      end
      vectors++;
      if (done !== ed) begin
        miscompares++;
        $display("FAIL counted n=%0d g=%0d done @t+%0d: got %b want %b", n, g, offs, done, ed);
      end
      if (ep) begin
        vectors++;
        if (pulse_idx !== ei) begin
          miscompares++;
          $display("FAIL counted n=%0d g=%0d pulse_idx @t+%0d: got %0d want %0d", n, g, offs, pulse_idx, ei);
        end
      end
      step();
    end
  endtask

  task automatic test_zero_count();
    repeat_cnt = 8'd0; gap = 8'd3; forever_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({busy, pulse_o, done} !== 3'b001) begin
      miscompares++;
      $display("FAIL zero_count t+1: got busy/pulse/done=%b want 001", {busy, pulse_o, done});
    end
    for (int offs = 2; offs <= 4; offs++) begin
      step();
      vectors++;
      if ({busy, pulse_o, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL zero_count t+%0d: got busy/pulse/done=%b want 000", offs, {busy, pulse_o, done});
      end
    end
  endtask

  task automatic test_start_stop_same();
    repeat_cnt = 8'd4; gap = 8'd0; forever_mode = 1'b0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int offs = 1; offs <= 3; offs++) begin
      vectors++;
      if ({busy, pulse_o, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL start_stop_same t+%0d: got busy/pulse/done=%b want 000", offs, {busy, pulse_o, done});
      end
      step();
    end
  endtask

  task automatic test_forever();
    logic [7:0] ei;
    repeat_cnt = 8'd0; gap = 8'd0; forever_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0; forever_mode = 1'b0;
    for (int offs = 1; offs <= 300; offs++) begin
      ei = 8'((offs - 1) % 256);
      vectors++;
      if ({busy, pulse_o, done} !== 3'b110) begin
        miscompares++;
        $display("FAIL forever t+%0d busy/pulse/done: got %b want 110", offs, {busy, pulse_o, done});
      end
      vectors++;
      if (pulse_idx !== ei) begin
        miscompares++;
        $display("FAIL forever t+%0d pulse_idx: got %0d want %0d", offs, pulse_idx, ei);
      end
      if (offs < 300) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int offs = 301; offs <= 304; offs++) begin
      vectors++;
      if ({busy, pulse_o, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL forever_stop t+%0d busy/pulse/done: got %b want 000", offs, {busy, pulse_o, done});
      end
      vectors++;
      if (pulse_idx !== 8'd43) begin
        miscompares++;
        $display("FAIL forever_stop t+%0d pulse_idx hold: got %0d want 43", offs, pulse_idx);
      end
      step();
    end
  endtask

  // count=10 gap=3: pulses at t+1,t+5; a start at t+3 is ignored; stop at t+6.
  task automatic test_stop_and_busy_start();
    logic ep, eb, ee;
    repeat_cnt = 8'd10; gap = 8'd3; forever_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int offs = 1; offs <= 15; offs++) begin
      ep = (offs == 1) || (offs == 5);
      eb = (offs <= 6);
      ee = (offs >= 4) ? EXP_ERR : 1'b0;
      vectors++;
      if (pulse_o !== ep) begin
        miscompares++;
        $display("FAIL stop_run pulse_o @t+%0d: got %b want %b", offs, pulse_o, ep);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL stop_run busy @t+%0d: got %b want %b", offs, busy, eb);
      end
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL stop_run done @t+%0d: got %b want 0", offs, done);
      end
      vectors++;
      if (err !== ee) begin
        miscompares++;
        $display("FAIL stop_run err @t+%0d: got %b want %b", offs, err, ee);
      end
      if (offs == 5 || offs >= 7) begin
        vectors++;
        if (pulse_idx !== 8'd1) begin
          miscompares++;
          $display("FAIL stop_run pulse_idx @t+%0d: got %0d want 1", offs, pulse_idx);
        end
      end
      if (offs == 3) begin
        start = 1'b1; repeat_cnt = 8'd0; gap = 8'd0; forever_mode = 1'b1;
      end else if (offs == 4) begin
        start = 1'b0; forever_mode = 1'b0;
      end else if (offs == 6) begin
        stop = 1'b1;
      end else if (offs == 7) begin
        stop = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    repeat_cnt = 8'd4; gap = 8'd2; forever_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    vectors++;
    if (pulse_o !== 1'b1 || pulse_idx !== 8'd2) begin
      miscompares++;
      $display("FAIL midrun pre-reset t+7: got pulse=%b idx=%0d want 1 2", pulse_o, pulse_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, pulse_o, done, err} !== 4'b0000 || pulse_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL midrun async reset: got busy/pulse/done/err=%b idx=%0d want 0000 0",
               {busy, pulse_o, done, err}, pulse_idx);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if ({busy, pulse_o, done, err} !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrun after release cycle %0d: got busy/pulse/done/err=%b want 0000",
                 c, {busy, pulse_o, done, err});
      end
    end
    test_counted(4, 2);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_counted(4, 2);
    test_counted(3, 0);
    test_counted(1, 5);
    test_zero_count();
    test_start_stop_same();
    test_forever();
    test_stop_and_busy_start();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
